mem_port_arbiter: RTL and testbench

Sequencer and arbiter that lets the pipelined MIPS core share one single-ported, fixed-latency memory between instruction fetch (IF stage) and data access (MEM stage). It grants one requester at a time and drives the memory port through an issue/wait/response state machine. It returns read data with a one-cycle valid pulse and asserts a global `stall` that freezes PC and all pipeline registers while any request is outstanding.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one fixed-latency single-ported memory between
// instruction fetch and data access, with pipeline stall generation.
module mem_port_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned   CW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(LAT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    owner_t        r_owner;
    owner_t        r_last_grant;
    owner_t        w_grant_owner;
    logic          r_op_wr;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;
    logic          w_d_req;
    logic          w_grant;
    logic          w_capture;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        w_d_req       = d_rd | d_wr;
        w_grant       = 1'b0;
        w_grant_owner = OWN_IF;
        if (r_state == S_IDLE) begin
            if (if_req && w_d_req) begin
                w_grant       = 1'b1;
                w_grant_owner = (r_last_grant == OWN_IF) ? OWN_D : OWN_IF;
            end else if (w_d_req) begin
                w_grant       = 1'b1;
                w_grant_owner = OWN_D;
            end else if (if_req) begin
                w_grant       = 1'b1;
                w_grant_owner = OWN_IF;
            end
        end
    end

    assign w_capture = (r_state == S_WAIT) && (r_cnt == ONE_C);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        if_valid   = 1'b0;
        d_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = r_op_wr;
                w_state_nx = r_op_wr ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (w_capture) w_state_nx = S_RESP;
            end
            S_RESP: begin
                if_valid   = (r_owner == OWN_IF);
                d_valid    = (r_owner == OWN_D);
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_owner      <= OWN_IF;
            r_last_grant <= OWN_IF;
            r_op_wr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_grant_owner;
                r_last_grant <= w_grant_owner;
                if (w_grant_owner == OWN_D) begin
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                    r_op_wr <= d_wr;
                end else begin
                    r_addr  <= if_addr;
                    r_op_wr <= 1'b0;
                end
            end
            if (r_state == S_ISSUE && !r_op_wr) begin
                r_cnt <= LAT_C;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - ONE_C;
            end
            if (w_capture) begin
                if (r_owner == OWN_IF) r_if_rdata <= mem_rdata;
                else                   r_d_rdata  <= mem_rdata;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign stall     = (if_req & ~if_valid) | (w_d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: fixed-latency memory model,
// directed vector table, contention/reset sequences and a randomized phase.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input int i);
        return (i == 4) ? 32'h8C010004 : (32'hA5000000 | 32'(i));
    endfunction

    // Memory model: read data appears exactly LAT cycles after the strobe cycle.
    logic        mem_init = 1'b1;
    logic [31:0] mem [64];
    logic        pv [LAT];
    logic [31:0] pa [LAT];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= mem_en & ~mem_we;
            pa[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = pv[LAT-1] ? mem[pa[LAT-1][7:2]] : 32'hBAD0BAD0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          kind;      // 0 fetch, 1 load, 2 store, 3 rd+wr
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_we;
        int          exp_lat;
    } vec_t;

    vec_t        vt [8];
    logic [31:0] d_hold;

    task automatic run_vec(input vec_t v, input int idx);
        int   got;
        logic own_v, oth_v;
        got = -1;
        @(posedge clock); #1;
        case (v.kind)
            0: begin if_req = 1'b1; if_addr = v.addr; end
            1: begin d_rd = 1'b1; d_addr = v.addr; end
            2: begin d_wr = 1'b1; d_addr = v.addr; d_wdata = v.wdata; end
            default: begin d_rd = 1'b1; d_wr = 1'b1; d_addr = v.addr; d_wdata = v.wdata; end
        endcase
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            own_v = (v.kind == 0) ? if_valid : d_valid;
            oth_v = (v.kind == 0) ? d_valid : if_valid;
            chk($sformatf("v%0d other_valid", idx), 32'(oth_v), 32'h0);
            chk($sformatf("v%0d stall", idx), 32'(stall), 32'(!own_v));
            if (j == 1) begin
                chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'h1);
                chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
                chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
                if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
            end else begin
                chk($sformatf("v%0d mem_en_off", idx), 32'(mem_en), 32'h0);
            end
            if (own_v) begin
                got = j;
                if (v.kind == 0) begin
                    chk($sformatf("v%0d if_rdata", idx), if_rdata, v.exp_rdata);
                end else if (v.kind == 1) begin
                    chk($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_rdata);
                    d_hold = v.exp_rdata;
                end else begin
                    chk($sformatf("v%0d d_rdata_held", idx), d_rdata, d_hold);
                end
                break;
            end
        end
        chk($sformatf("v%0d latency", idx), 32'(got), 32'(v.exp_lat));
        @(posedge clock); #1;
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    // Both requesters rise in the same cycle; winner valid at G+LAT+2, loser LAT+3 later.
    task automatic contend(input bit d_first, input logic [31:0] da, input logic [31:0] ia,
                           input string nm);
        int ti, td;
        ti = -1; td = -1;
        @(posedge clock); #1;
        reset = 1'b1; if_req = 1'b1; if_addr = ia; d_rd = 1'b1; d_wr = 1'b0; d_addr = da;
        for (int j = 0; j < 15; j++) begin
            @(negedge clock);
            if (j == 1) begin
                chk({nm, " issue1_en"}, 32'(mem_en), 32'h1);
                chk({nm, " issue1_addr"}, mem_addr, d_first ? da : ia);
            end
            if (j == LAT + 4) begin
                chk({nm, " issue2_en"}, 32'(mem_en), 32'h1);
                chk({nm, " issue2_addr"}, mem_addr, d_first ? ia : da);
            end
            if (if_valid) begin
                ti = j;
                chk({nm, " if_rdata"}, if_rdata, pat(int'(ia[7:2])));
            end
            if (d_valid) begin
                td = j;
                chk({nm, " d_rdata"}, d_rdata, pat(int'(da[7:2])));
            end
            if (j == 2 * LAT + 5) chk({nm, " stall_end"}, 32'(stall), 32'h0);
            @(posedge clock); #1;
            if (ti == j) if_req = 1'b0;
            if (td == j) d_rd = 1'b0;
        end
        chk({nm, " winner_lat"}, 32'(d_first ? td : ti), 32'(LAT + 2));
        chk({nm, " loser_lat"}, 32'(d_first ? ti : td), 32'(2 * LAT + 5));
    endtask

    logic [31:0] refmem [64];

    // Reference: requests are served one at a time; a read occupies the port
    // for LAT+3 cycles from grant, a write for 3; ties go to the non-last winner.
    task automatic random_phase(input int ncyc);
        bit          ip, dp, dwr, last_d, gi, gd, ev_i, ev_d, iss_we;
        int          ivc, dvc, free_at, issue_c, k;
        logic [31:0] ia, da, dw, iexp, dexp, ihold, dhold, iss_addr, iss_wd;
        ip = 0; dp = 0; dwr = 0; last_d = 0; ivc = -1; dvc = -1; free_at = 0; issue_c = -1;
        ia = '0; da = '0; dw = '0; iexp = '0; dexp = '0; ihold = '0; dhold = '0;
        iss_addr = '0; iss_wd = '0; iss_we = 0;
        for (int i = 0; i < 64; i++) refmem[i] = pat(i);
        @(posedge clock); #1;
        reset = 1'b0; mem_init = 1'b1; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        @(posedge clock); #1;
        mem_init = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock); #1;
            reset = 1'b1;
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; ivc = -1; ia = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1; dvc = -1; da = 32'($urandom_range(0, 15)) << 2; dw = $urandom;
                k = $urandom_range(0, 4);
                dwr = (k >= 2);
                d_rd = (k < 2) || (k == 4);
                d_wr = dwr;
            end
            if_req = ip; if_addr = ia;
            if (!dp) begin d_rd = 1'b0; d_wr = 1'b0; end
            d_addr = da; d_wdata = dw;
            if (c >= free_at) begin
                gi = ip && (ivc < 0);
                gd = dp && (dvc < 0);
                if (gi && gd) begin
                    if (last_d) gd = 0; else gi = 0;
                end
                if (gd) begin
                    dvc = c + (dwr ? 2 : LAT + 2);
                    if (dwr) refmem[da[7:2]] = dw; else dexp = refmem[da[7:2]];
                    free_at = dvc + 1; last_d = 1;
                    issue_c = c + 1; iss_addr = da; iss_we = dwr; iss_wd = dw;
                end else if (gi) begin
                    ivc = c + LAT + 2; iexp = refmem[ia[7:2]];
                    free_at = ivc + 1; last_d = 0;
                    issue_c = c + 1; iss_addr = ia; iss_we = 0;
                end
            end
            @(negedge clock);
            ev_i = ip && (ivc == c);
            ev_d = dp && (dvc == c);
            if (ev_i) ihold = iexp;
            if (ev_d && !dwr) dhold = dexp;
            chk("rnd if_valid", 32'(if_valid), 32'(ev_i));
            chk("rnd d_valid", 32'(d_valid), 32'(ev_d));
            chk("rnd if_rdata", if_rdata, ihold);
            chk("rnd d_rdata", d_rdata, dhold);
            chk("rnd stall", 32'(stall), 32'((ip && !ev_i) || (dp && !ev_d)));
            chk("rnd mem_en", 32'(mem_en), 32'(c == issue_c));
            if (c == issue_c) begin
                chk("rnd mem_addr", mem_addr, iss_addr);
                chk("rnd mem_we", 32'(mem_we), 32'(iss_we));
                if (iss_we) chk("rnd mem_wdata", mem_wdata, iss_wd);
            end
            if (ev_i) ip = 0;
            if (ev_d) dp = 0;
        end
        @(posedge clock); #1;
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 32'h10, 32'h0,        32'h8C010004, 1'b0, LAT + 2};
        vt[1] = '{2, 32'h20, 32'hDEADBEEF, 32'h0,        1'b1, 2};
        vt[2] = '{1, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, LAT + 2};
        vt[3] = '{3, 32'h24, 32'h12345678, 32'h0,        1'b1, 2};
        vt[4] = '{0, 32'h24, 32'h0,        32'h12345678, 1'b0, LAT + 2};
        vt[5] = '{2, 32'h10, 32'hCAFEF00D, 32'h0,        1'b1, 2};
        vt[6] = '{0, 32'h10, 32'h0,        32'hCAFEF00D, 1'b0, LAT + 2};
        vt[7] = '{1, 32'h24, 32'h0,        32'h12345678, 1'b0, LAT + 2};

        // Reset held low with both requesters active.
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            mem_init = 1'b0; if_req = 1'b1; d_rd = 1'b1; d_addr = 32'h08; if_addr = 32'h0C;
            @(negedge clock);
            chk("rst mem_en", 32'(mem_en), 32'h0);
            chk("rst mem_we", 32'(mem_we), 32'h0);
            chk("rst if_valid", 32'(if_valid), 32'h0);
            chk("rst d_valid", 32'(d_valid), 32'h0);
            chk("rst if_rdata", if_rdata, 32'h0);
            chk("rst d_rdata", d_rdata, 32'h0);
            chk("rst mem_addr", mem_addr, 32'h0);
            chk("rst mem_wdata", mem_wdata, 32'h0);
            chk("rst stall", 32'(stall), 32'h1);
        end

        contend(1'b1, 32'h08, 32'h0C, "cont1");
        d_hold = pat(2);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Last table entry was a data access, so the next tie goes to fetch.
        contend(1'b0, 32'h14, 32'h18, "cont2");

        // Reset asserted while a fetch is waiting on memory.
        @(posedge clock); #1;
        if_req = 1'b1; if_addr = 32'h30;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rstw issue", 32'(mem_en), 32'h1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rstw wait_valid", 32'(if_valid), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1; if_req = 1'b0;
        for (int j = 3; j < 9; j++) begin
            @(negedge clock);
            chk("rstw if_valid", 32'(if_valid), 32'h0);
            chk("rstw d_valid", 32'(d_valid), 32'h0);
            chk("rstw mem_en", 32'(mem_en), 32'h0);
            chk("rstw stall", 32'(stall), 32'h0);
        end
        begin
            vec_t v;
            v = '{0, 32'h30, 32'h0, pat(12), 1'b0, LAT + 2};
            run_vec(v, 8);
        end

        random_phase(2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
